// File: rtl/iosc_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: widths, unit-enable bits, FSM codes.
// Buffer depth depends on IOSC_FETCH_PREFETCH_EN (defined: 2-entry prefetch, undefined: 1-entry demand fetch).
package iosc_fetch_pkg;

    localparam int IOSC_DATA_WIDTH = 8;
    localparam int IOSC_ADDR_WIDTH = 8;

    // Decoder output-enable bit that requests the next instruction
    localparam int IOSC_EN_INS_PC = 11;

`ifdef IOSC_FETCH_PREFETCH_EN
    localparam int FETCH_DEPTH = 2;
`else
    localparam int FETCH_DEPTH = 1;
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/iosc_fetch_if.sv
// Instruction-memory read bus between the fetch unit (master) and memory (slave).
// Data returns in the same cycle as mem_ack.
interface iosc_fetch_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) ();
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/iosc_fetch_fetch_buf.sv
// Small shift-style instruction FIFO; entry 0 is always the head, so any DEPTH >= 1 works.
// Flush dominates push/pop; the caller guarantees a push never overflows.
module fetch_buf #(
    parameter int DEPTH      = 1,
    parameter int DATA_WIDTH = 8,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] head,
    output logic [CW-1:0]         count
);
    logic [DATA_WIDTH-1:0] entries_reg [DEPTH];
    logic [DATA_WIDTH-1:0] shift_in    [DEPTH];
    logic [CW-1:0]         count_reg;
    logic [CW-1:0]         wr_idx;
    logic                  pop_ok;

    assign pop_ok = pop && (count_reg != '0);
    // With a simultaneous pop the new word lands one slot lower, after the shift
    assign wr_idx = pop_ok ? (count_reg - CW'(1)) : count_reg;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_shift
        if (gi < DEPTH - 1) begin : g_mid
            assign shift_in[gi] = entries_reg[gi + 1];
        end else begin : g_last
            assign shift_in[gi] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            count_reg <= '0;
        end else if (push && !pop_ok) begin
            count_reg <= count_reg + CW'(1);
        end else if (pop_ok && !push) begin
            count_reg <= count_reg - CW'(1);
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (push && (wr_idx == CW'(i))) begin
                entries_reg[i] <= push_data;
            end else if (pop_ok) begin
                entries_reg[i] <= shift_in[i];
            end
        end
    end

    assign head  = (count_reg != '0) ? entries_reg[0] : '0;
    assign count = count_reg;
endmodule

// File: rtl/iosc_fetch.sv
// Instruction fetch unit: issues memory reads, buffers returned words, feeds the decoder.
// IOSC_FETCH_PREFETCH_EN defined: prefetch into a 2-entry buffer; undefined: demand fetch, 1 entry.
module iosc_fetch
    import iosc_fetch_pkg::*;
#(
    parameter int DATA_WIDTH = IOSC_DATA_WIDTH,
    parameter int ADDR_WIDTH = IOSC_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           i_unit_oen,
    input  logic                  i_pc_load,
    input  logic [ADDR_WIDTH-1:0] i_pc_value,
    iosc_fetch_if.master          mem,
    output logic [DATA_WIDTH-1:0] o_ins,
    output logic                  o_ins_valid,
    output logic                  o_stall
);
    localparam int CW = $clog2(FETCH_DEPTH + 1);

    fetch_state_e          state_reg;
    logic [ADDR_WIDTH-1:0] fetch_addr_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic                  mem_req_reg;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] head;
    logic                  rd, ack, push, pop, issue;
    logic                  unused_oen;

    assign rd         = i_unit_oen[IOSC_EN_INS_PC];
    assign unused_oen = ^{i_unit_oen[15:IOSC_EN_INS_PC+1], i_unit_oen[IOSC_EN_INS_PC-1:0]};

    // Acks only count while a request is actually on the bus
    assign ack  = mem.mem_ack && mem_req_reg && (state_reg != ST_IDLE);
    assign push = (state_reg == ST_REQ) && ack && !i_pc_load;
    assign pop  = rst_n && rd && (count != '0) && !i_pc_load;

    assign o_ins_valid = rst_n && (count != '0) && !i_pc_load;
    assign o_ins       = o_ins_valid ? head : '0;
    assign o_stall     = rst_n && rd && ((count == '0) || i_pc_load);

`ifdef IOSC_FETCH_PREFETCH_EN
    logic [CW:0] count_next;
    // A new request is allowed only if its data will still fit after this cycle's push/pop
    assign count_next = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
    assign issue      = !i_pc_load && (count_next < (CW+1)'(FETCH_DEPTH));
`else
    assign issue = !i_pc_load && rd && (count == '0) && !push;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            fetch_addr_reg <= '0;
            mem_req_reg    <= 1'b0;
            mem_addr_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_pc_load) begin
                        fetch_addr_reg <= i_pc_value;
                    end else if (issue) begin
                        state_reg    <= ST_REQ;
                        mem_req_reg  <= 1'b1;
                        mem_addr_reg <= fetch_addr_reg;
                    end
                end
                ST_REQ: begin
                    if (i_pc_load) begin
                        fetch_addr_reg <= i_pc_value;
                        if (ack) begin
                            state_reg   <= ST_IDLE;
                            mem_req_reg <= 1'b0;
                        end else begin
                            // Bus must finish the old read; its data is thrown away
                            state_reg <= ST_DISCARD;
                        end
                    end else if (ack) begin
                        fetch_addr_reg <= fetch_addr_reg + ADDR_WIDTH'(1);
                        if (issue) begin
                            mem_addr_reg <= fetch_addr_reg + ADDR_WIDTH'(1);
                        end else begin
                            state_reg   <= ST_IDLE;
                            mem_req_reg <= 1'b0;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (i_pc_load) begin
                        fetch_addr_reg <= i_pc_value;
                    end
                    if (ack) begin
                        state_reg   <= ST_IDLE;
                        mem_req_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    mem_req_reg <= 1'b0;
                end
            endcase
        end
    end

    assign mem.mem_req  = mem_req_reg;
    assign mem.mem_addr = mem_addr_reg;

    fetch_buf #(
        .DEPTH      (FETCH_DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (mem.mem_rdata),
        .pop       (pop),
        .flush     (i_pc_load),
        .head      (head),
        .count     (count)
    );
endmodule

// File: tb/tb_iosc_fetch.sv
// Cycle vector bench for iosc_fetch; the vector table follows the build mode (IOSC_FETCH_PREFETCH_EN).
// Delivered instructions are checked against a scoreboard of acked words expected to reach the decoder.
module tb_iosc_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] unit_oen = '0;
    logic        pc_load = 1'b0;
    logic [7:0]  pc_value = '0;
    logic [7:0]  ins;
    logic        ins_valid, stall;

    iosc_fetch_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) mem_bus ();

    iosc_fetch #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_unit_oen  (unit_oen),
        .i_pc_load   (pc_load),
        .i_pc_value  (pc_value),
        .mem         (mem_bus),
        .o_ins       (ins),
        .o_ins_valid (ins_valid),
        .o_stall     (stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, rd, ld;
        logic [7:0] pcv;
        logic       ack;
        logic [7:0] rdata;
        logic       keep;   // acked word should reach the decoder later
        logic       e_req;
        logic [7:0] e_addr;
        logic       e_valid, e_stall;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];
    int         n_vec = 0;
    int         n_bad = 0;

    function automatic vec_t mk(logic rst, logic rd, logic ld, logic [7:0] pcv, logic ack,
                                logic [7:0] rdata, logic keep, logic e_req, logic [7:0] e_addr,
                                logic e_valid, logic e_stall);
        vec_t v;
        v.rst = rst; v.rd = rd; v.ld = ld; v.pcv = pcv; v.ack = ack; v.rdata = rdata;
        v.keep = keep; v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_stall = e_stall;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic rd, input logic ld, input logic [7:0] pcv,
                         input logic ack, input logic [7:0] rdata);
        rst_n              = rst;
        unit_oen           = 16'($urandom);
        unit_oen[11]       = rd;
        pc_load            = ld;
        pc_value           = pcv;
        mem_bus.mem_ack    = ack;
        mem_bus.mem_rdata  = rdata;
    endtask

    // Delivery check: whenever the decoder takes a word, it must be the oldest expected one
    task automatic sb_check(input int idx);
        logic [7:0] e;
        if (ins_valid && unit_oen[11]) begin
            if (exp_q.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL sb_underflow @%0d: got %0h expected none", idx, ins);
            end else begin
                e = exp_q.pop_front();
                chk("sb_ins", idx, ins, e);
            end
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench hung");
    end

    initial begin
        logic       found;
        logic [7:0] hand_addr;
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = '0;

`ifdef IOSC_FETCH_PREFETCH_EN
        hand_addr = 8'h00;
        vecs.push_back(mk(0,0,0,8'h00,0,8'h00,0, 0,8'h00,0,0));
        vecs.push_back(mk(1,0,0,8'h00,0,8'h00,0, 0,8'h00,0,0));  // prefetch issues without rd
        vecs.push_back(mk(1,0,0,8'h00,1,8'h25,1, 1,8'h00,0,0));
        vecs.push_back(mk(1,0,0,8'h00,1,8'h31,1, 1,8'h01,1,0));
        vecs.push_back(mk(1,0,0,8'h00,0,8'h00,0, 0,8'h00,1,0));  // full: no request
        vecs.push_back(mk(1,1,0,8'h00,0,8'h00,0, 0,8'h00,1,0));
        vecs.push_back(mk(1,1,0,8'h00,0,8'h00,0, 1,8'h02,1,0));
        vecs.push_back(mk(1,0,0,8'h00,0,8'h00,0, 1,8'h02,0,0));
        vecs.push_back(mk(1,1,0,8'h00,1,8'h40,1, 1,8'h02,0,1));
        vecs.push_back(mk(1,0,0,8'h00,1,8'h41,1, 1,8'h03,1,0));
        vecs.push_back(mk(1,1,0,8'h00,0,8'h00,0, 0,8'h00,1,0));
        vecs.push_back(mk(1,1,0,8'h00,1,8'h42,1, 1,8'h04,1,0));  // push+pop same cycle
        vecs.push_back(mk(1,0,0,8'h00,1,8'h43,1, 1,8'h05,1,0));
        vecs.push_back(mk(1,1,0,8'h00,0,8'h00,0, 0,8'h00,1,0));
        vecs.push_back(mk(1,1,0,8'h00,0,8'h00,0, 1,8'h06,1,0));
        vecs.push_back(mk(1,1,0,8'h00,0,8'h00,0, 1,8'h06,0,1));
        vecs.push_back(mk(1,0,1,8'h40,0,8'h00,0, 1,8'h06,0,0));  // redirect while pending
        vecs.push_back(mk(1,0,0,8'h00,1,8'h99,0, 1,8'h06,0,0));  // dropped
        vecs.push_back(mk(1,0,0,8'h00,0,8'h00,0, 0,8'h00,0,0));
        vecs.push_back(mk(1,0,0,8'h00,1,8'h5A,0, 1,8'h40,0,0));
        vecs.push_back(mk(0,0,0,8'h00,0,8'h00,0, 1,8'h41,0,0));  // reset mid-request
        vecs.push_back(mk(1,0,0,8'h00,1,8'hEE,0, 0,8'h00,0,0));  // stray ack
        vecs.push_back(mk(1,0,0,8'h00,0,8'h00,0, 1,8'h00,0,0));
`else
        hand_addr = 8'h81;
        vecs.push_back(mk(0,1,0,8'h00,0,8'h00,0, 0,8'h00,0,0));  // stall forced low in reset
        vecs.push_back(mk(1,0,0,8'h00,0,8'h00,0, 0,8'h00,0,0));
        vecs.push_back(mk(1,0,0,8'h00,0,8'h00,0, 0,8'h00,0,0));  // no fetch without rd
        vecs.push_back(mk(1,1,0,8'h00,0,8'h00,0, 0,8'h00,0,1));
        vecs.push_back(mk(1,1,0,8'h00,0,8'h00,0, 1,8'h00,0,1));  // ack delayed 3 cycles
        vecs.push_back(mk(1,1,0,8'h00,0,8'h00,0, 1,8'h00,0,1));
        vecs.push_back(mk(1,1,0,8'h00,0,8'h00,0, 1,8'h00,0,1));
        vecs.push_back(mk(1,1,0,8'h00,1,8'h25,1, 1,8'h00,0,1));
        vecs.push_back(mk(1,1,0,8'h00,0,8'h00,0, 0,8'h00,1,0));
        vecs.push_back(mk(1,0,0,8'h00,0,8'h00,0, 0,8'h00,0,0));
        vecs.push_back(mk(1,1,0,8'h00,0,8'h00,0, 0,8'h00,0,1));
        vecs.push_back(mk(1,0,0,8'h00,1,8'h31,1, 1,8'h01,0,0));
        vecs.push_back(mk(1,0,0,8'h00,0,8'h00,0, 0,8'h00,1,0));
        vecs.push_back(mk(1,1,0,8'h00,0,8'h00,0, 0,8'h00,1,0));
        vecs.push_back(mk(1,1,0,8'h00,0,8'h00,0, 0,8'h00,0,1));
        vecs.push_back(mk(1,1,1,8'h40,0,8'h00,0, 1,8'h02,0,1));  // redirect while 0x02 pending
        vecs.push_back(mk(1,1,0,8'h00,0,8'h00,0, 1,8'h02,0,1));
        vecs.push_back(mk(1,1,0,8'h00,1,8'h99,0, 1,8'h02,0,1));  // dropped
        vecs.push_back(mk(1,1,0,8'h00,0,8'h00,0, 0,8'h00,0,1));
        vecs.push_back(mk(1,1,0,8'h00,1,8'h5A,1, 1,8'h40,0,1));
        vecs.push_back(mk(1,1,0,8'h00,0,8'h00,0, 0,8'h00,1,0));
        vecs.push_back(mk(1,0,1,8'hFF,0,8'h00,0, 0,8'h00,0,0));
        vecs.push_back(mk(1,1,0,8'h00,0,8'h00,0, 0,8'h00,0,1));
        vecs.push_back(mk(1,1,0,8'h00,1,8'h77,1, 1,8'hFF,0,1));
        vecs.push_back(mk(1,1,0,8'h00,0,8'h00,0, 0,8'h00,1,0));
        vecs.push_back(mk(1,1,0,8'h00,0,8'h00,0, 0,8'h00,0,1));  // address wrapped to 0x00
        vecs.push_back(mk(0,0,0,8'h00,0,8'h00,0, 1,8'h00,0,0));  // reset mid-request
        vecs.push_back(mk(1,0,0,8'h00,1,8'hEE,0, 0,8'h00,0,0));  // stray ack
        vecs.push_back(mk(1,0,0,8'h00,0,8'h00,0, 0,8'h00,0,0));
        vecs.push_back(mk(1,1,0,8'h00,1,8'h11,0, 0,8'h00,0,1));  // ack in IDLE ignored
        vecs.push_back(mk(1,1,0,8'h00,1,8'h12,0, 1,8'h00,0,1));
        vecs.push_back(mk(1,0,0,8'h00,0,8'h00,0, 0,8'h00,1,0));
        vecs.push_back(mk(1,1,1,8'h10,0,8'h00,0, 0,8'h00,0,1));  // redirect flushes full buffer
        vecs.push_back(mk(1,0,0,8'h00,0,8'h00,0, 0,8'h00,0,0));
        vecs.push_back(mk(1,1,0,8'h00,0,8'h00,0, 0,8'h00,0,1));
        vecs.push_back(mk(1,0,0,8'h00,1,8'h3C,1, 1,8'h10,0,0));
        vecs.push_back(mk(1,1,0,8'h00,0,8'h00,0, 0,8'h00,1,0));
        vecs.push_back(mk(1,0,0,8'h00,0,8'h00,0, 0,8'h00,0,0));
        vecs.push_back(mk(1,1,0,8'h00,0,8'h00,0, 0,8'h00,0,1));
        vecs.push_back(mk(1,1,1,8'h80,1,8'hAB,0, 1,8'h11,0,1));  // redirect beats same-cycle ack
        vecs.push_back(mk(1,1,0,8'h00,0,8'h00,0, 0,8'h00,0,1));
        vecs.push_back(mk(1,1,0,8'h00,1,8'hCD,1, 1,8'h80,0,1));
        vecs.push_back(mk(1,1,0,8'h00,0,8'h00,0, 0,8'h00,1,0));
        vecs.push_back(mk(1,0,0,8'h00,0,8'h00,0, 0,8'h00,0,0));
`endif

        drive(0, 0, 0, 8'h00, 0, 8'h00);
        repeat (2) @(posedge clk);

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            drive(vecs[k].rst, vecs[k].rd, vecs[k].ld, vecs[k].pcv, vecs[k].ack, vecs[k].rdata);
            if (vecs[k].keep) exp_q.push_back(vecs[k].rdata);
            #1;
            $display("vec %0d: rst=%0b rd=%0b ld=%0b ack=%0b -> req=%0b addr=%0h valid=%0b ins=%0h stall=%0b",
                     k, vecs[k].rst, vecs[k].rd, vecs[k].ld, vecs[k].ack,
                     mem_bus.mem_req, mem_bus.mem_addr, ins_valid, ins, stall);
            chk("mem_req", k, 8'(mem_bus.mem_req), 8'(vecs[k].e_req));
            if (vecs[k].e_req) chk("mem_addr", k, mem_bus.mem_addr, vecs[k].e_addr);
            chk("ins_valid", k, 8'(ins_valid), 8'(vecs[k].e_valid));
            chk("stall", k, 8'(stall), 8'(vecs[k].e_stall));
            if (!vecs[k].e_valid && !vecs[k].ld) chk("ins_zero", k, ins, 8'h00);
            sb_check(k);
        end

        // Hand sequence: hold rd, wait (bounded) for a request, ack it, expect data the next cycle
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            drive(1, 1, 0, 8'h00, 0, 8'h00);
            #1;
            found = mem_bus.mem_req;
        end
        if (!found) begin
            n_vec++; n_bad++;
            $display("FAIL req_timeout: got no request expected request within 10 cycles");
        end else begin
            chk("hand_addr", 100, mem_bus.mem_addr, hand_addr);
            mem_bus.mem_ack   = 1'b1;
            mem_bus.mem_rdata = 8'hC3;
            exp_q.push_back(8'hC3);
            $display("hand: ack addr=%0h data=c3", mem_bus.mem_addr);
            @(negedge clk);
            drive(1, 1, 0, 8'h00, 0, 8'h00);
            #1;
            $display("hand: next cycle valid=%0b ins=%0h", ins_valid, ins);
            chk("hand_valid", 101, 8'(ins_valid), 8'h01);
            sb_check(101);
        end
        @(negedge clk);
        drive(1, 0, 0, 8'h00, 0, 8'h00);

        chk("sb_empty", 102, 8'(exp_q.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
